gp_reg_bank: RTL

Parametrised general-purpose register bank: the next-generation register file for the datapath, generalising the fixed 8×8 R/T bank to DEPTH registers of WIDTH bits with two independent read ports. Each register is a small counter/loader driven by the shared FunSel code, with a selectable wrap or saturate policy on increment and decrement. Optional write-to-read bypass is provided. Per-register zero flags and a registered overflow event feed the ALU flag logic and the controller.

---
 rtl/gp_reg_pkg.sv | 52 +++++
 rtl/gp_reg_bank_if.sv | 27 ++
 rtl/gp_reg_cell.sv | 40 ++++
 rtl/gp_reg_bank.sv | 69 ++++++
 4 files changed

// File: rtl/gp_reg_pkg.sv
// rtl/gp_reg_pkg.sv - FunSel codes and next-value rule shared by the register bank
package gp_reg_pkg;

  localparam logic [1:0] FS_CLR  = 2'b00;
  localparam logic [1:0] FS_LOAD = 2'b01;
  localparam logic [1:0] FS_DEC  = 2'b10;
  localparam logic [1:0] FS_INC  = 2'b11;

  // Widest register the shared rule supports; callers zero-extend into it.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic [MAX_W-1:0] value;
    logic             evt;
  } next_t;

  function automatic next_t next_value(
    input logic [MAX_W-1:0] value,
    input logic [1:0]       funsel,
    input logic [MAX_W-1:0] load,
    input int               width,
    input logic             saturate
  );
    logic [MAX_W-1:0] ones;
    next_t            r;
    for (int b = 0; b < MAX_W; b++) ones[b] = (b < width);
    r.value = value;
    r.evt   = 1'b0;
    case (funsel)
      FS_CLR:  r.value = '0;
      FS_LOAD: r.value = load;
      FS_DEC: begin
        if (value == '0) begin
          r.evt   = 1'b1;
          r.value = saturate ? '0 : ones;
        end else begin
          r.value = value - MAX_W'(1);
        end
      end
      default: begin
        if (value == ones) begin
          r.evt   = 1'b1;
          r.value = saturate ? ones : '0;
        end else begin
          r.value = value + MAX_W'(1);
        end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gp_reg_bank_if.sv
// rtl/gp_reg_bank_if.sv - command and read-port bundle of the register bank
interface gp_reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int SEL_W = $clog2(DEPTH);

  logic [WIDTH-1:0] load;
  logic [1:0]       funsel;
  logic [DEPTH-1:0] rsel;
  logic [SEL_W-1:0] o1sel;
  logic [SEL_W-1:0] o2sel;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic [DEPTH-1:0] zero;
  logic             ovf;

  modport master (
    output load, funsel, rsel, o1sel, o2sel,
    input  o1, o2, zero, ovf
  );

  modport slave (
    input  load, funsel, rsel, o1sel, o2sel,
    output o1, o2, zero, ovf
  );
endinterface

// File: rtl/gp_reg_cell.sv
// rtl/gp_reg_cell.sv - one counter/loader register with wrap or saturate policy
module gp_reg_cell
  import gp_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               SATURATE  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       funsel,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] next,
  output logic             evt
);

  next_t nv;

  always_comb nv = next_value(MAX_W'(q), funsel, MAX_W'(load), WIDTH, SATURATE != 0);

  assign next = nv.value[WIDTH-1:0];
  assign evt  = en & nv.evt;

  // Upper bits of the shared rule are always zero for a narrower register.
  if (WIDTH < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^nv.value[MAX_W-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= next;
    end
  end

endmodule

// File: rtl/gp_reg_bank.sv
// rtl/gp_reg_bank.sv - DEPTH x WIDTH register bank with two read ports, zero flags and overflow event
module gp_reg_bank
  import gp_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 8,
  parameter int               SEL_W     = $clog2(DEPTH),
  parameter int               SATURATE  = 0,
  parameter int               BYPASS    = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  gp_reg_bank_if.slave bus
);

  logic [WIDTH-1:0] q   [DEPTH];
  logic [WIDTH-1:0] nxt [DEPTH];
  logic [DEPTH-1:0] evt;
  logic [WIDTH-1:0] o1_mux;
  logic [WIDTH-1:0] o2_mux;
  logic             ovf_r;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    gp_reg_cell #(
      .WIDTH     (WIDTH),
      .SATURATE  (SATURATE),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (bus.rsel[i]),
      .funsel (bus.funsel),
      .load   (bus.load),
      .q      (q[i]),
      .next   (nxt[i]),
      .evt    (evt[i])
    );
    assign bus.zero[i] = (q[i] == '0);
  end

  // Selects past DEPTH match no register and leave the port at zero.
  always_comb begin
    o1_mux = '0;
    o2_mux = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.o1sel == SEL_W'(i)) begin
        o1_mux = (BYPASS != 0 && !rst && bus.rsel[i]) ? nxt[i] : q[i];
      end
      if (bus.o2sel == SEL_W'(i)) begin
        o2_mux = (BYPASS != 0 && !rst && bus.rsel[i]) ? nxt[i] : q[i];
      end
    end
  end

  assign bus.o1 = o1_mux;
  assign bus.o2 = o2_mux;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= |evt;
    end
  end

  assign bus.ovf = ovf_r;

endmodule
